// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one PAT_W-bit history matcher across NUM_CH serial channels.
// Define SEQDET_MATCH_CNT_EN to build per-channel 16-bit saturating match counters.
module seq_detect_scheduler #(
  parameter int               NUM_CH      = 4,
  parameter int               PAT_W       = 8,
  parameter logic             TAIL_BIT    = 1'b1,
  parameter logic [PAT_W-1:0] RST_PATTERN = 8'hAA,
  parameter int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  output logic              busy,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [15:0]       cnt_val
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]  flush_idx_q, flush_idx_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] hist_q [NUM_CH];
  logic [PAT_W-1:0] hist_d [NUM_CH];
  logic             match_valid_q, match_valid_d;
  logic [CH_W-1:0]  match_ch_q, match_ch_d;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  cand;
  logic             run_go;

  // Scan downward so the closest valid channel at/after rr_ptr wins last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (ch_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign run_go = (state_q == RUN) && enable && !clear;

  always_comb begin
    ch_ready = '0;
    if (run_go && grant_found) begin
      ch_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    flush_idx_d   = flush_idx_q;
    pattern_d     = pattern_q;
    hist_d        = hist_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    case (state_q)
      IDLE: begin
        pattern_d = cfg_pattern;
        if (clear) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end else if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end else if (!enable) begin
          state_d = IDLE;
        end else if (grant_found) begin
          match_valid_d = (hist_q[grant_idx] == pattern_q) && (ch_bit[grant_idx] == TAIL_BIT);
          if (match_valid_d) begin
            match_ch_d = grant_idx;
          end
          hist_d[grant_idx] = {hist_q[grant_idx][PAT_W-2:0], ch_bit[grant_idx]};
          rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      FLUSH: begin
        hist_d[flush_idx_q] = '0;
        rr_ptr_d            = '0;
        if (flush_idx_q == CH_W'(NUM_CH - 1)) begin
          flush_idx_d = '0;
          state_d     = enable ? RUN : IDLE;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      flush_idx_q   <= '0;
      pattern_q     <= RST_PATTERN;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      flush_idx_q   <= flush_idx_d;
      pattern_q     <= pattern_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      hist_q        <= hist_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign busy        = (state_q == FLUSH);

`ifdef SEQDET_MATCH_CNT_EN
  logic [15:0] cnt_q [NUM_CH];
  logic [15:0] cnt_d [NUM_CH];

  always_comb begin
    cnt_d = cnt_q;
    if (match_valid_d && (cnt_q[grant_idx] != 16'hFFFF)) begin
      cnt_d[grant_idx] = cnt_q[grant_idx] + 16'd1;
    end
    if (state_q == FLUSH) begin
      cnt_d[flush_idx_q] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_val = (int'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : 16'h0000;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_val        = 16'h0000;
`endif

endmodule
